// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for the 8-bit parallel ADC. It divides aclk into adc_clk,
// drops the converter pipeline-latency samples, and streams the captured samples out on valid/ready.
module adc_conv_ctrl #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int CNT_W      = 16,
    parameter int PIPE_DELAY = 3
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_cont,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [CNT_W-1:0]  sample_count,
    output logic              adc_clk,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    // state | meaning
    // IDLE  | waiting for start, adc_clk held low
    // FLUSH | adc_clk running, discarding PIPE_DELAY pipeline samples
    // RUN   | adc_clk running, capturing samples
    // DONE  | single burst finished, one-cycle done pulse
    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    localparam int FL_W = (PIPE_DELAY > 1) ? $clog2(PIPE_DELAY) : 1;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_reload;
    logic [DIV_W-1:0] div_start;
    logic [CNT_W-1:0] remaining;
    logic [FL_W-1:0]  flush_cnt;
    logic             cont_mode;
    logic             running;
    logic             sample_evt;
    logic             capture;

    // A divider value of 0 behaves as 1, so the reload value is N-1.
    assign div_start  = (clk_div == '0) ? '0 : clk_div - 1'b1;
    assign running    = (state == FLUSH) || (state == RUN);
    assign sample_evt = running && !stop && adc_clk && (div_cnt == '0);
    assign capture    = sample_evt && (state == RUN);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            adc_clk    <= 1'b0;
            div_cnt    <= '0;
            div_reload <= '0;
            remaining  <= '0;
            flush_cnt  <= '0;
            cont_mode  <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;

            // A sample that lands while the previous one is still pending is dropped.
            if (capture) begin
                if (m_valid && !m_ready) begin
                    overflow <= 1'b1;
                end else begin
                    m_data  <= adc_data;
                    m_valid <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        cont_mode  <= mode_cont;
                        div_reload <= div_start;
                        div_cnt    <= div_start;
                        remaining  <= sample_count;
                        flush_cnt  <= '0;
                        overflow   <= 1'b0;
                        if (!mode_cont && (sample_count == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            busy    <= 1'b1;
                            adc_clk <= 1'b1;
                            state   <= (PIPE_DELAY == 0) ? RUN : FLUSH;
                        end
                    end
                end
                FLUSH, RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        adc_clk <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        if (div_cnt == '0) begin
                            adc_clk <= ~adc_clk;
                            div_cnt <= div_reload;
                        end else begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                        if (sample_evt) begin
                            if (state == FLUSH) begin
                                if (int'(flush_cnt) == PIPE_DELAY - 1)
                                    state <= RUN;
                                else
                                    flush_cnt <= flush_cnt + 1'b1;
                            end else if (!cont_mode) begin
                                if (remaining == CNT_W'(1)) begin
                                    state   <= DONE;
                                    done    <= 1'b1;
                                    busy    <= 1'b0;
                                    adc_clk <= 1'b0;
                                end else begin
                                    remaining <= remaining - 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adc_conv_ctrl.md
Name: adc_conv_ctrl

Overview:
- Conversion sequencer for the 8-bit parallel ADC behind the AXI ADC peripheral.
- Generates `adc_clk` from the register-programmed divider and discards the ADC pipeline-latency samples after start.
- Captures `adc_data` in single-burst or continuous mode and presents samples on a valid/ready stream to the capture FIFO.
- Reports busy/done/overflow status back to the `REG_CTL` register file.

Parameters:
- DATA_W, 8, ADC sample width.
- DIV_W, 16, width of clock-divider field.
- CNT_W, 16, width of sample-count field.
- PIPE_DELAY, 3, number of ADC samples discarded after each start (converter pipeline latency).

Ports:
- aclk  in  1  system clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse from REG_CTL write; starts a conversion run.
- stop  in  1  one-cycle pulse; aborts a run.
- mode_cont  in  1  0 = single burst of sample_count samples, 1 = continuous until stop.
- clk_div  in  DIV_W  REG_CLK_DIV value N; adc_clk half-period in aclk cycles.
- sample_count  in  CNT_W  samples per burst in single mode.
- adc_clk  out  1  clock to ADC.
- adc_data  in  DATA_W  ADC parallel output, stable around adc_clk falling edge.
- m_data  out  DATA_W  captured sample.
- m_valid  out  1  sample available.
- m_ready  in  1  downstream accepts sample.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of single burst.
- overflow  out  1  sticky: a sample was dropped.

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, adc_clk=0, m_data=0, m_valid=0, busy=0, done=0, overflow=0, all counters 0.
- States: IDLE, FLUSH, RUN, DONE.
- Divider:
  - N = clk_div, with 0 treated as 1.
  - clk_div and mode_cont are latched at the accepted start and ignored mid-run.
  - adc_clk toggles every N aclk cycles while in FLUSH/RUN, so the period is 2N aclk cycles.
  - adc_clk is held 0 in IDLE/DONE.
- Sample event: the aclk edge on which adc_clk goes 1→0. adc_data is registered on that edge.
- IDLE:
  - start=1 → latch config, clear the flush counter, busy=1.
  - Next state is FLUSH, or RUN if PIPE_DELAY=0.
  - adc_clk goes high on the cycle after start.
  - If single mode and sample_count=0 → go directly to DONE; no adc_clk edges.
- FLUSH: discard sample events; after PIPE_DELAY events → RUN. The count continues without gap.
- RUN:
  - Each sample event loads m_data and sets m_valid.
  - In single mode the remaining count is decremented; after the sample_count-th event → DONE.
- DONE: one cycle; done=1, busy=0 next, → IDLE.
- Output handshake:
  - Transfer occurs when m_valid && m_ready; m_valid clears the next cycle unless a new sample event lands on the same cycle, in which case m_valid stays 1 with the new data.
  - Sample event while m_valid && !m_ready: new sample dropped, m_data unchanged, overflow set (sticky until the next accepted start). The sample still counts toward sample_count.
  - m_valid may remain set into IDLE until consumed.
- stop:
  - In FLUSH/RUN → IDLE next cycle; adc_clk forced 0; no done pulse; busy=0.
  - In IDLE, stop is ignored.
- start while busy is ignored. start and stop in the same cycle: stop wins, so from IDLE nothing happens.
- Reset mid-run: immediate return to reset values; pending sample lost.
- Counter width: sample_count up to 2^CNT_W−1; no wrap in continuous mode (no counter used).

Test Plan:
- Reset mid-RUN in continuous mode (areset pulse) → adc_clk, m_valid, busy, overflow all 0 asynchronously; start after release works normally.
- clk_div=4, single, sample_count=5, PIPE_DELAY=3, m_ready=1, adc_data random per adc_clk rise:
  - adc_clk period is 8 aclk cycles.
  - First 3 falling edges produce no m_valid.
  - Exactly 5 m_valid pulses, each carrying the adc_data value present at its falling edge.
  - done pulses once; busy drops the same cycle it pulses.
- clk_div=0, single, sample_count=2 → behaves as N=1: adc_clk period 2 cycles; 2 samples then done.
- Continuous, clk_div=2, m_ready=1; stop after 10 samples → adc_clk low next cycle, no done, busy=0; start again → fresh 3-sample flush.
- Single, sample_count=4, m_ready=0 throughout:
  - First RUN sample is held on m_data.
  - overflow=1 after the second sample event.
  - done still pulses after 4 events.
  - Raising m_ready consumes one sample only.
- start with sample_count=0 in single mode → done pulse 1 cycle after start, adc_clk never toggles. start asserted during busy → ignored, sample total unchanged.
